// File: rtl/cp0_exc_ctrl_if.sv
// Signal bundle between the exception sequencer and the MEM stage, stall/flush network and CP0.
// The slave modport is the sequencer's view; master is the environment driving it.
interface cp0_exc_ctrl_if;
  logic        mem_valid_i;
  logic [4:0]  exc_flags_i;
  logic [31:0] mem_pc_i;
  logic        mem_in_delayslot_i;
  logic [5:0]  int_i;
  logic        timer_int_i;
  logic [31:0] status_i;
  logic [31:0] cause_i;
  logic [31:0] epc_i;
  logic        stallreq_id_i;
  logic        stallreq_ex_i;
  logic        stallreq_mem_i;

  logic [5:0]  stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic [31:0] excepttype_o;
  logic [31:0] cur_inst_addr_o;
  logic        is_in_delayslot_o;
  logic        busy_o;
  logic [1:0]  fsm_state;

  modport slave (
    input  mem_valid_i, exc_flags_i, mem_pc_i, mem_in_delayslot_i,
    input  int_i, timer_int_i, status_i, cause_i, epc_i,
    input  stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
    output stall_o, flush_o, new_pc_o, excepttype_o, cur_inst_addr_o,
    output is_in_delayslot_o, busy_o, fsm_state
  );

  modport master (
    output mem_valid_i, exc_flags_i, mem_pc_i, mem_in_delayslot_i,
    output int_i, timer_int_i, status_i, cause_i, epc_i,
    output stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
    input  stall_o, flush_o, new_pc_o, excepttype_o, cur_inst_addr_o,
    input  is_in_delayslot_o, busy_o, fsm_state
  );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// Exception/interrupt sequencer: picks one winner per cycle, pulses its code to CP0,
// then holds a pipeline flush with the redirect PC. Otherwise merges stage stall requests.
module cp0_exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0020,
  parameter int          FLUSH_CYCLES = 2
) (
  input logic           clk,
  input logic           rst,
  cp0_exc_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  localparam logic [31:0] CODE_INT     = 32'h0000_0001;
  localparam logic [31:0] CODE_SYSCALL = 32'h0000_0008;
  localparam logic [31:0] CODE_INVALID = 32'h0000_000a;
  localparam logic [31:0] CODE_OVF     = 32'h0000_000c;
  localparam logic [31:0] CODE_TRAP    = 32'h0000_000d;
  localparam logic [31:0] CODE_ERET    = 32'h0000_000e;
  localparam logic [3:0]  FLUSH_LOAD   = 4'(FLUSH_CYCLES - 1);

  state_t      state;
  logic [3:0]  flush_cnt;
  logic [7:0]  pend;
  logic        irq;
  logic        take;
  logic        busy;
  logic [5:0]  stall_merge;
  logic [31:0] code;
  logic        is_eret;
  logic        unused_bits;

  assign unused_bits = &{1'b0, bus.status_i[31:16], bus.status_i[7:2],
                         bus.cause_i[31:10], bus.cause_i[7:0]};

  // Interrupt lines line up with Status.IM[7:0]; timer shares the top line with int_i[5].
  assign pend = {bus.int_i[5] | bus.timer_int_i, bus.int_i[4:0], bus.cause_i[9:8]}
              & bus.status_i[15:8];
  assign irq  = (pend != 8'd0) & bus.status_i[0] & ~bus.status_i[1];

  always_comb begin
    stall_merge = 6'b000000;
    if (bus.stallreq_mem_i)     stall_merge = 6'b011111;
    else if (bus.stallreq_ex_i) stall_merge = 6'b001111;
    else if (bus.stallreq_id_i) stall_merge = 6'b000111;
  end

  assign busy = (state != IDLE);

  // A MEM-stage stall holds the instruction in place, so it cannot be taken yet.
  assign take = (state == IDLE) & bus.mem_valid_i & ~stall_merge[4]
              & (irq | (bus.exc_flags_i != 5'd0));

  always_comb begin
    code    = 32'd0;
    is_eret = 1'b0;
    if (irq)                     code = CODE_INT;
    else if (bus.exc_flags_i[1]) code = CODE_INVALID;
    else if (bus.exc_flags_i[0]) code = CODE_SYSCALL;
    else if (bus.exc_flags_i[2]) code = CODE_TRAP;
    else if (bus.exc_flags_i[3]) code = CODE_OVF;
    else if (bus.exc_flags_i[4]) begin
      code    = CODE_ERET;
      is_eret = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                 <= IDLE;
      flush_cnt             <= 4'd0;
      bus.flush_o           <= 1'b0;
      bus.new_pc_o          <= 32'd0;
      bus.excepttype_o      <= 32'd0;
      bus.cur_inst_addr_o   <= 32'd0;
      bus.is_in_delayslot_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.excepttype_o <= 32'd0;
          bus.flush_o      <= 1'b0;
          flush_cnt        <= 4'd0;
          if (take) begin
            state                 <= COMMIT;
            bus.excepttype_o      <= code;
            bus.cur_inst_addr_o   <= bus.mem_pc_i;
            bus.is_in_delayslot_o <= bus.mem_in_delayslot_i;
            bus.flush_o           <= 1'b1;
            bus.new_pc_o          <= is_eret ? bus.epc_i : EXC_VECTOR;
          end
        end
        COMMIT: begin
          bus.excepttype_o <= 32'd0;
          if (FLUSH_LOAD != 4'd0) begin
            state       <= FLUSH;
            flush_cnt   <= FLUSH_LOAD;
            bus.flush_o <= 1'b1;
          end else begin
            state       <= IDLE;
            bus.flush_o <= 1'b0;
          end
        end
        FLUSH: begin
          bus.excepttype_o <= 32'd0;
          if (flush_cnt <= 4'd1) begin
            state       <= IDLE;
            flush_cnt   <= 4'd0;
            bus.flush_o <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - 4'd1;
          end
        end
        default: begin
          state            <= IDLE;
          flush_cnt        <= 4'd0;
          bus.flush_o      <= 1'b0;
          bus.excepttype_o <= 32'd0;
        end
      endcase
    end
  end

  // Flush wins over any stall request, including in the take cycle itself.
  assign bus.stall_o   = (busy | take) ? 6'b000000 : stall_merge;
  assign bus.busy_o    = busy;
  assign bus.fsm_state = state;

endmodule
